// File: rtl/float2int_pkg.sv
// Shared single-precision float definitions for the float2int / int2float converters.
package float_pkg;

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    SPECIAL_CASES,
    CONVERT,
    PACK,
    PUT_Z
  } state_t;

  localparam logic signed [9:0] FLOAT_BIAS = 10'sd127;
  localparam logic [31:0]       INT_MIN    = 32'h8000_0000;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MANT_MSB = 22;

  // Largest unbiased exponent that still fits a signed 32-bit result.
  localparam logic signed [9:0] EXP_MAX_INT = 10'sd30;
  // Exponent at which the 32-bit mantissa register holds the integer part.
  localparam logic signed [9:0] EXP_ALIGNED = 10'sd31;

  function automatic logic signed [9:0] unbiased_exp(input logic [31:0] f);
    return $signed({2'b00, f[EXP_MSB:EXP_LSB]}) - FLOAT_BIAS;
  endfunction

endpackage

// File: rtl/float2int_if.sv
// stb/ack operand and result channels of the float-to-int converter.
interface float2int_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/float2int.sv
// IEEE-754 single to signed 32-bit integer, truncating toward zero and saturating
// to INT_MIN; multi-cycle FSM with a one-bit-per-cycle right-shift normaliser.
module float2int
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  float2int_if.slave  io
);

  state_t             state_q;
  logic [31:0]        a_q;
  logic [31:0]        a_m_q;
  logic signed [9:0]  a_e_q;
  logic               a_s_q;
  logic [31:0]        z_q;
  logic               in_ack_q;
  logic               out_stb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= GET_A;
      a_q       <= '0;
      a_m_q     <= '0;
      a_e_q     <= '0;
      a_s_q     <= 1'b0;
      z_q       <= '0;
      in_ack_q  <= 1'b0;
      out_stb_q <= 1'b0;
    end else begin
      unique case (state_q)
        GET_A: begin
          if (in_ack_q && io.input_a_stb) begin
            a_q      <= io.input_a;
            in_ack_q <= 1'b0;
            state_q  <= UNPACK;
          end else begin
            in_ack_q <= 1'b1;
          end
        end
        UNPACK: begin
          a_m_q   <= {1'b1, a_q[MANT_MSB:0], 8'b0};
          a_e_q   <= unbiased_exp(a_q);
          a_s_q   <= a_q[SIGN_BIT];
          state_q <= SPECIAL_CASES;
        end
        SPECIAL_CASES: begin
          if (a_e_q < 10'sd0) begin
            z_q     <= '0;
            state_q <= PUT_Z;
          end else if (a_e_q > EXP_MAX_INT) begin
            z_q     <= INT_MIN;
            state_q <= PUT_Z;
          end else begin
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          // Bits shifted out are the fraction; dropping them truncates toward zero.
          if (a_e_q < EXP_ALIGNED) begin
            a_m_q <= a_m_q >> 1;
            a_e_q <= a_e_q + 10'sd1;
          end else begin
            state_q <= PACK;
          end
        end
        PACK: begin
          z_q     <= a_s_q ? -a_m_q : a_m_q;
          state_q <= PUT_Z;
        end
        PUT_Z: begin
          if (out_stb_q && io.output_z_ack) begin
            out_stb_q <= 1'b0;
            state_q   <= GET_A;
          end else begin
            out_stb_q <= 1'b1;
          end
        end
        default: state_q <= GET_A;
      endcase
    end
  end

  assign io.input_a_ack  = in_ack_q;
  assign io.output_z     = z_q;
  assign io.output_z_stb = out_stb_q;

endmodule

// File: tb/tb_float2int.sv
// Scoreboard bench for float2int: randomized operands and stalls against a real-arithmetic model.
module tb_float2int;

  logic clk = 1'b0;
  logic rst;
  float2int_if io();

  float2int dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          stb_rises = 0;
  bit          rand_ack = 1'b0;
  bit          man_ack = 1'b0;
  logic        prev_stb = 1'b0;
  logic        prev_hs = 1'b0;
  logic [31:0] prev_z = '0;

  // Reference: value = (1 + m/2^23) * 2^(e-127), truncated toward zero, saturated.
  function automatic logic [31:0] ref_conv(input logic [31:0] f);
    int  ex;
    real v;
    int  iv;
    ex = int'(f[30:23]);
    if (ex < 127) return 32'h0;
    if (ex == 255) return 32'h8000_0000;
    v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (ex - 127));
    if (v >= 2147483648.0) return 32'h8000_0000;
    iv = $rtoi(v);
    return f[31] ? 32'(-iv) : 32'(iv);
  endfunction

  function automatic int ref_lat(input logic [31:0] f);
    int ex;
    ex = int'(f[30:23]);
    if (ex >= 127 && ex <= 157) return 36 - (ex - 127);
    return 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    io.output_z_ack = rand_ack ? ($urandom_range(0, 3) != 0) : man_ack;
  end

  // Monitor: latency, hold-under-backpressure and result checks.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stb = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      if (io.input_a_ack && io.input_a_stb) accept_cyc = cyc + 1;
      if (prev_stb && !prev_hs) begin
        check("hold_stb", 32'(io.output_z_stb), 32'h1);
        check("hold_z", io.output_z, prev_z);
      end
      if (io.output_z_stb && !prev_stb) begin
        stb_rises++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %h expected no result", io.output_z);
        end else begin
          check("latency", 32'(cyc - accept_cyc), 32'(sb[0].lat));
        end
      end
      if (io.output_z_stb && io.output_z_ack && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("result_%h", e.a), io.output_z, e.z);
      end
      prev_stb = io.output_z_stb;
      prev_hs  = io.output_z_stb && io.output_z_ack;
      prev_z   = io.output_z;
    end
  end

  task automatic send(input logic [31:0] a, input int idle);
    exp_t e;
    int   t;
    repeat (idle) @(posedge clk);
    @(posedge clk);
    #2;
    io.input_a     = a;
    io.input_a_stb = 1'b1;
    e.a   = a;
    e.z   = ref_conv(a);
    e.lat = ref_lat(a);
    sb.push_back(e);
    t = 0;
    @(negedge clk);
    while (!io.input_a_ack && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!io.input_a_ack) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got input_a_ack 0 expected 1 for %h", a);
    end
    @(posedge clk);
    #2;
    io.input_a_stb = 1'b0;
    io.input_a     = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dir [10];
    logic [31:0] a;
    int          rises0;
    int          t;
    int          sel;
    int          bexp [6];

    dir = '{32'h3F80_0000, 32'hC020_0000, 32'h4EFF_FFFF, 32'h7F80_0000, 32'h7FC0_0000,
            32'hCF00_0000, 32'h3F7F_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h4120_0000};
    bexp = '{126, 127, 157, 158, 255, 0};

    rst = 1'b1;
    io.input_a = '0;
    io.input_a_stb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ack", 32'(io.input_a_ack), 32'h0);
    check("reset_out_stb", 32'(io.output_z_stb), 32'h0);
    check("reset_z", io.output_z, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ack_before_edge", 32'(io.input_a_ack), 32'h0);
    @(negedge clk);
    check("in_ack_first_edge", 32'(io.input_a_ack), 32'h1);

    man_ack = 1'b1;
    foreach (dir[i]) send(dir[i], 0);
    wait_idle();

    // Backpressure: ten stalled cycles, then exactly one ack.
    @(negedge clk);
    man_ack = 1'b0;
    repeat (2) @(negedge clk);
    send(32'h4B00_0005, 0);
    t = 0;
    while (!io.output_z_stb && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bp_stb_seen", 32'(io.output_z_stb), 32'h1);
    repeat (10) @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    @(negedge clk);
    check("bp_stb_dropped", 32'(io.output_z_stb), 32'h0);
    check("bp_in_ack_low", 32'(io.input_a_ack), 32'h0);
    check("bp_one_consumed", 32'(sb.size()), 32'h0);
    @(negedge clk);
    check("bp_in_ack_back", 32'(io.input_a_ack), 32'h1);

    // Reset during convert discards the transaction.
    man_ack = 1'b1;
    send(32'h3F80_0000, 0);
    sb.delete();
    rises0 = stb_rises;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ack", 32'(io.input_a_ack), 32'h0);
    check("midrst_out_stb", 32'(io.output_z_stb), 32'h0);
    check("midrst_z", io.output_z, 32'h0);
    repeat (45) @(negedge clk);
    check("midrst_no_output", 32'(stb_rises), 32'(rises0));
    send(32'h4120_0000, 0);
    wait_idle();

    rand_ack = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 3);
      a = $urandom;
      if (sel == 1 || sel == 2) a[30:23] = 8'(127 + $urandom_range(0, 30));
      else if (sel == 3) a[30:23] = 8'(bexp[$urandom_range(0, 5)]);
      send(a, $urandom_range(0, 2));
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
